// File: rtl/uart_rx_os_pkg.sv
// Shared UART receive definitions: FSM state encoding, oversampling constants
// and the stop-phase counter width helper.
package uart_rx_os_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam int unsigned OS_RATE = 16;
  localparam int unsigned OS_MID  = 7;

  // Oversample counter must reach SB_TICK-1 in the stop phase; never narrower than 4 bits.
  function automatic int unsigned cnt_width(input int unsigned sb_tick);
    int unsigned w;
    w = $clog2(sb_tick);
    if (w > 32'd4) begin
      return w;
    end else begin
      return 32'd4;
    end
  endfunction

endpackage

// File: rtl/uart_rx_os_sync.sv
// Two-flop synchroniser for a single asynchronous level; reset value selectable
// so an idle-high serial line does not look like a start edge out of reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_os.sv
// 16x-oversampling 8N1 UART receiver: deserialises LSB-first frames and presents
// each byte with a one-cycle done strobe and a stop-bit framing-error flag.
module uart_rx_os
  import uart_rx_os_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            busy
);

  localparam int SCW = int'(cnt_width(SB_TICK));
  localparam int NCW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SCW-1:0] C_S_ZERO  = SCW'(0);
  localparam logic [SCW-1:0] C_S_ONE   = SCW'(1);
  localparam logic [SCW-1:0] C_S_MID   = SCW'(OS_MID);
  localparam logic [SCW-1:0] C_S_BIT   = SCW'(OS_RATE - 1);
  localparam logic [SCW-1:0] C_S_STOP  = SCW'(SB_TICK - 1);
  localparam logic [NCW-1:0] C_N_ZERO  = NCW'(0);
  localparam logic [NCW-1:0] C_N_ONE   = NCW'(1);
  localparam logic [NCW-1:0] C_N_LAST  = NCW'(DBIT - 1);

  rx_state_e       r_state;
  rx_state_e       w_state_nxt;
  logic [SCW-1:0]  r_s_cnt;
  logic [SCW-1:0]  w_s_cnt_nxt;
  logic [NCW-1:0]  r_n_cnt;
  logic [NCW-1:0]  w_n_cnt_nxt;
  logic [DBIT-1:0] r_shift;
  logic [DBIT-1:0] w_shift_nxt;
  logic [DBIT-1:0] r_dout;
  logic            r_done;
  logic            r_ferr;
  logic            w_rx_s;
  logic            w_frame_end;
  logic            w_busy;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_rx_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (rx),
    .o_q     (w_rx_s)
  );

  // FSM state and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_s_cnt <= C_S_ZERO;
      r_n_cnt <= C_N_ZERO;
      r_shift <= {DBIT{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_s_cnt <= w_s_cnt_nxt;
      r_n_cnt <= w_n_cnt_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Next-state and counter logic; everything except start detection waits for a tick.
  always_comb begin
    w_state_nxt = r_state;
    w_s_cnt_nxt = r_s_cnt;
    w_n_cnt_nxt = r_n_cnt;
    w_shift_nxt = r_shift;
    case (r_state)
      ST_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = ST_START;
          w_s_cnt_nxt = C_S_ZERO;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        if (!s_tick) begin
          w_state_nxt = ST_START;
        end else if (r_s_cnt == C_S_MID) begin
          // Line back high at mid start bit means a glitch, not a frame.
          if (!w_rx_s) begin
            w_state_nxt = ST_DATA;
            w_s_cnt_nxt = C_S_ZERO;
            w_n_cnt_nxt = C_N_ZERO;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_s_cnt_nxt = r_s_cnt + C_S_ONE;
        end
      end
      ST_DATA: begin
        if (!s_tick) begin
          w_state_nxt = ST_DATA;
        end else if (r_s_cnt == C_S_BIT) begin
          w_s_cnt_nxt = C_S_ZERO;
          w_shift_nxt = {w_rx_s, r_shift[DBIT-1:1]};
          if (r_n_cnt == C_N_LAST) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_n_cnt_nxt = r_n_cnt + C_N_ONE;
          end
        end else begin
          w_s_cnt_nxt = r_s_cnt + C_S_ONE;
        end
      end
      ST_STOP: begin
        if (!s_tick) begin
          w_state_nxt = ST_STOP;
        end else if (r_s_cnt == C_S_STOP) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_s_cnt_nxt = r_s_cnt + C_S_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_s_cnt_nxt = C_S_ZERO;
        w_n_cnt_nxt = C_N_ZERO;
      end
    endcase
  end

  // Output decode from current state: frame completion and activity.
  always_comb begin
    w_frame_end = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      ST_IDLE:  w_busy = 1'b0;
      ST_START: w_busy = 1'b1;
      ST_DATA:  w_busy = 1'b1;
      ST_STOP:  w_frame_end = s_tick && (r_s_cnt == C_S_STOP);
      default:  w_busy = 1'b0;
    endcase
  end

  // Registered result: strobe for one cycle, data and error held until the next frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done <= 1'b0;
      r_dout <= {DBIT{1'b0}};
      r_ferr <= 1'b0;
    end else begin
      r_done <= w_frame_end;
      if (w_frame_end) begin
        r_dout <= r_shift;
        r_ferr <= ~w_rx_s;
      end
    end
  end

  assign dout         = r_dout;
  assign rx_done_tick = r_done;
  assign frame_err    = r_ferr;
  assign busy         = w_busy;

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: serial frames are driven tick-accurately and
// each completed frame is compared against the value queued when it was sent.
module tb_uart_rx_os;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic       s_tick = 1'b0;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       busy;

  int   m_val = 4;
  bit   tick_en = 1'b1;
  int   tick_cnt = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   done_cnt = 0;
  logic prev_done = 1'b0;
  logic [8:0] sb_q[$];
  logic [8:0] mon_exp;

  always #5 clk = ~clk;

  uart_rx_os #(.DBIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx           (rx),
    .s_tick       (s_tick),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  // mod-M tick source
  always @(posedge clk) begin
    if (!tick_en) begin
      s_tick <= 1'b0;
    end else if (tick_cnt >= m_val - 1) begin
      tick_cnt <= 0;
      s_tick   <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1;
      s_tick   <= 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && rx_done_tick) begin
      check_eq("done_single_cycle", {31'd0, prev_done}, 32'd0);
      done_cnt++;
      if (sb_q.size() == 0) begin
        check_eq("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_exp = sb_q.pop_front();
        check_eq("dout", {24'd0, dout}, {24'd0, mon_exp[7:0]});
        check_eq("frame_err", {31'd0, frame_err}, {31'd0, mon_exp[8]});
      end
    end
    prev_done = reset_n ? rx_done_tick : 1'b0;
  end

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (s_tick) k++;
    end
  endtask

  task automatic send_bit(input logic b, input int n);
    #1 rx = b;
    wait_ticks(n);
  endtask

  task automatic send_frame(input logic [7:0] data, input bit good_stop, input int freeze_bit);
    sb_q.push_back({~good_stop, data});
    send_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) begin
      #1 rx = data[i];
      if (i == freeze_bit) begin
        tick_en = 1'b0;
        repeat (100) @(posedge clk);
        #1 check_eq("busy_frozen", {31'd0, busy}, 32'd1);
        tick_en = 1'b1;
      end
      wait_ticks(16);
    end
    if (good_stop) begin
      send_bit(1'b1, 16);
    end else begin
      // short low stop so the line is idle again before the receiver's next mid-start check
      send_bit(1'b0, 10);
      send_bit(1'b1, 6);
    end
  endtask

  task automatic wait_drain(input string tag);
    int k = 0;
    while (sb_q.size() != 0 && k < 5000) begin
      @(posedge clk);
      k++;
    end
    check_eq(tag, sb_q.size(), 32'd0);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] part;
    part = 8'h96;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_dout", {24'd0, dout}, 32'd0);
    check_eq("rst_done", {31'd0, rx_done_tick}, 32'd0);
    check_eq("rst_ferr", {31'd0, frame_err}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_ticks(20);

    // good frame
    send_frame(8'hA5, 1'b1, -1);
    wait_drain("t1_drain");
    wait_ticks(4);
    #1;
    check_eq("t1_count", done_cnt, 32'd1);
    check_eq("t1_busy_low", {31'd0, busy}, 32'd0);
    check_eq("t1_dout_hold", {24'd0, dout}, 32'h0000_00A5);

    // start glitch
    send_bit(1'b0, 3);
    @(posedge clk);
    #1 check_eq("t2_busy_start", {31'd0, busy}, 32'd1);
    send_bit(1'b1, 20);
    #1;
    check_eq("t2_busy_idle", {31'd0, busy}, 32'd0);
    check_eq("t2_count", done_cnt, 32'd1);
    check_eq("t2_dout", {24'd0, dout}, 32'h0000_00A5);

    // bad stop bit, then recovery
    send_frame(8'h3C, 1'b0, -1);
    wait_drain("t3_drain");
    wait_ticks(20);
    #1;
    check_eq("t3_count", done_cnt, 32'd2);
    check_eq("t3_ferr_hold", {31'd0, frame_err}, 32'd1);
    check_eq("t3_busy", {31'd0, busy}, 32'd0);
    send_frame(8'h01, 1'b1, -1);
    wait_drain("t3b_drain");
    #1;
    check_eq("t3b_count", done_cnt, 32'd3);
    check_eq("t3b_ferr_clr", {31'd0, frame_err}, 32'd0);

    // async reset mid-DATA
    send_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) send_bit(part[i], 16);
    send_bit(part[4], 5);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("t4_rst_dout", {24'd0, dout}, 32'd0);
    check_eq("t4_rst_done", {31'd0, rx_done_tick}, 32'd0);
    check_eq("t4_rst_ferr", {31'd0, frame_err}, 32'd0);
    check_eq("t4_rst_busy", {31'd0, busy}, 32'd0);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    wait_ticks(20);
    check_eq("t4_no_done", done_cnt, 32'd3);
    send_frame(8'h5A, 1'b1, -1);
    wait_drain("t4_drain");
    check_eq("t4_count", done_cnt, 32'd4);

    // back-to-back frames, tick every clock
    m_val = 1;
    wait_ticks(20);
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    wait_drain("t5_drain");
    #1;
    check_eq("t5_count", done_cnt, 32'd6);
    check_eq("t5_dout", {24'd0, dout}, 32'h0000_00FF);
    check_eq("t5_ferr", {31'd0, frame_err}, 32'd0);

    // tick stall mid-DATA
    m_val = 4;
    wait_ticks(20);
    send_frame(8'hC3, 1'b1, 4);
    wait_drain("t6_drain");
    wait_ticks(4);
    #1;
    check_eq("t6_count", done_cnt, 32'd7);
    check_eq("t6_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
